// File: rtl/decimator_stage_pkg.sv
// rtl/decimator_stage_pkg.sv - shared types and helpers for the decimator stage
package decimator_stage_pkg;

  localparam int LOG2_W = 5;

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_AVG    = 2'd1,
    MODE_PEAK   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  function automatic logic [LOG2_W-1:0] clamp_log2(input logic [LOG2_W-1:0] v, input int max_log2);
    return (int'(v) > max_log2) ? LOG2_W'(max_log2) : v;
  endfunction

endpackage

// File: rtl/decimator_stage_if.sv
// rtl/decimator_stage_if.sv - sample input and result handshake between filter, decimator and capture buffer
interface decimator_stage_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] out_min;
  logic [DATA_WIDTH-1:0] out_max;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_min, out_max
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_min, out_max
  );
endinterface

// File: rtl/decimator_stage_minmax_tracker.sv
// rtl/decimator_stage_minmax_tracker.sv - running signed min/max over a window
// The next-state values are exported so the window result can include the completing sample.
module minmax_tracker #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  init_i,
  input  logic                  update_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [DATA_WIDTH-1:0] min_d_o,
  output logic [DATA_WIDTH-1:0] max_d_o
);

  logic [DATA_WIDTH-1:0] min_q, max_q;

  always_comb begin
    min_d_o = min_q;
    max_d_o = max_q;
    if (init_i) begin
      min_d_o = sample_i;
      max_d_o = sample_i;
    end else if (update_i) begin
      if ($signed(sample_i) < $signed(min_q)) min_d_o = sample_i;
      if ($signed(sample_i) > $signed(max_q)) max_d_o = sample_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d_o;
      max_q <= max_d_o;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/decimator_stage.sv
// rtl/decimator_stage.sv - 2^L decimator with sample/average/peak modes and a held result register
module decimator_stage
  import decimator_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2   = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [LOG2_W-1:0] cfg_log2_i,
  input  logic              cfg_load_i,
  decimator_stage_if.slave  bus,
  output logic              overrun_o,
  output state_t            state_o
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2;

  mode_t                    mode_q;
  logic [LOG2_W-1:0]        log2_q;
  logic [MAX_LOG2-1:0]      cnt_q, cnt_d, last_idx;
  logic [MAX_LOG2:0]        win_len;
  logic signed [ACC_W-1:0]  acc_q, acc_d, sample_ext;
  logic [DATA_WIDTH-1:0]    first_q, first_d, avg_d, result_d;
  logic [DATA_WIDTH-1:0]    min_d, max_d, min_cur, max_cur;
  logic [DATA_WIDTH-1:0]    out_data_q, out_min_q, out_max_q;
  logic                     out_valid_q, overrun_q;
  state_t                   state_q;
  logic                     accept, first_sample, complete, load_out;

  // cfg_load wins over a coincident sample, so that sample never enters a window
  assign accept       = bus.in_valid && !cfg_load_i;
  assign first_sample = (cnt_q == '0);
  assign win_len      = (MAX_LOG2 + 1)'(1) << log2_q;
  assign last_idx     = MAX_LOG2'(win_len - (MAX_LOG2 + 1)'(1));
  assign complete     = accept && (cnt_q == last_idx);
  assign load_out     = complete && (!out_valid_q || bus.out_ready);

  assign sample_ext = {{MAX_LOG2{bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
  assign acc_d      = first_sample ? sample_ext : acc_q + sample_ext;
  assign first_d    = first_sample ? bus.in_data : first_q;
  assign avg_d      = DATA_WIDTH'(acc_d >>> log2_q);
  assign cnt_d      = complete ? '0 : cnt_q + MAX_LOG2'(1);

  always_comb begin
    case (mode_q)
      MODE_AVG:  result_d = avg_d;
      MODE_PEAK: result_d = max_d;
      default:   result_d = first_d;
    endcase
  end

  minmax_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_minmax (
    .clk_i   (clk_i),
    .clr_i   (rst_i || cfg_load_i),
    .init_i  (accept && first_sample),
    .update_i(accept && !first_sample),
    .sample_i(bus.in_data),
    .min_o   (min_cur),
    .max_o   (max_cur),
    .min_d_o (min_d),
    .max_d_o (max_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q      <= MODE_SAMPLE;
      log2_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      first_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      overrun_q   <= 1'b0;
      state_q     <= ST_RUN;
    end else if (cfg_load_i) begin
      mode_q      <= mode_t'(cfg_mode_i);
      log2_q      <= clamp_log2(cfg_log2_i, MAX_LOG2);
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      if (accept) begin
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        first_q <= first_d;
      end
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result_d;
        out_min_q   <= min_d;
        out_max_q   <= max_d;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (complete && !load_out) overrun_q <= 1'b1;
      state_q <= complete ? ST_DONE : ST_RUN;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_max   = out_max_q;
  assign overrun_o     = overrun_q;
  assign state_o       = state_q;

  logic unused_ok;
  assign unused_ok = ^{min_cur, max_cur};

endmodule

// File: tb/tb_decimator_stage.sv
// tb/tb_decimator_stage.sv - scoreboard bench for decimator_stage
module tb_decimator_stage;
  import decimator_stage_pkg::*;

  typedef struct {
    int d;
    int mn;
    int mx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_mode;
  logic [4:0] cfg_log2;
  logic       cfg_load;
  logic       overrun;
  state_t     st;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb[$];

  decimator_stage_if #(.DATA_WIDTH(16)) bus ();

  decimator_stage #(.DATA_WIDTH(16), .MAX_LOG2(12)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cfg_mode_i(cfg_mode),
    .cfg_log2_i(cfg_log2),
    .cfg_load_i(cfg_load),
    .bus       (bus),
    .overrun_o (overrun),
    .state_o   (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic push(input int d, input int mn, input int mx);
    exp_t e;
    e.d = d; e.mn = mn; e.mx = mx;
    sb.push_back(e);
  endtask

  task automatic send(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int mode, input int l2);
    cfg_load = 1'b1;
    cfg_mode = 2'(mode);
    cfg_log2 = 5'(l2);
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  // Monitor: every accepted result must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got data %0d, required no output", sx(bus.out_data));
      end else begin
        e = sb.pop_front();
        chk("out_data", sx(bus.out_data), e.d);
        chk("out_min", sx(bus.out_min), e.mn);
        chk("out_max", sx(bus.out_max), e.mx);
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_mode = '0; cfg_log2 = '0; cfg_load = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", sx(bus.out_data), 0);
    chk("reset_out_min", sx(bus.out_min), 0);
    chk("reset_out_max", sx(bus.out_max), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_state", int'(st), int'(ST_RUN));
    rst = 1'b0;

    // average of 4 samples
    cfg(1, 2);
    push(3, -2, 8);
    send(4); send(8); send(-2);
    chk("avg_not_early", int'(bus.out_valid), 0);
    send(5);
    chk("avg_latency", int'(bus.out_valid), 1);
    chk("avg_state_done", int'(st), int'(ST_DONE));
    idle();
    chk("avg_accepted", int'(bus.out_valid), 0);
    chk("avg_state_run", int'(st), int'(ST_RUN));

    // floor rounding of a negative mean
    cfg(1, 1);
    push(-4, -4, -3);
    send(-3); send(-4);
    idle();

    // peak mode with full-scale extremes
    cfg(2, 3);
    push(32767, -32768, 32767);
    send(100); send(32767); send(-5); send(-32768);
    send(0); send(1); send(-1); send(200);
    idle();

    // held result and overrun
    bus.out_ready = 1'b0;
    cfg(0, 0);
    push(10, 10, 10);
    send(10); send(20);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_held_data", sx(bus.out_data), 10);
    chk("ovr_held_valid", int'(bus.out_valid), 1);
    idle();
    bus.out_ready = 1'b1;
    idle();
    chk("ovr_accept_valid", int'(bus.out_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);

    // continuous sampling at L=1, then restart mid-window
    cfg(0, 1);
    chk("cfg_clears_overrun", int'(overrun), 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) push(i, i, i + 1);
      send(i + 1);
      chk("stream_valid", int'(bus.out_valid), i % 2);
    end
    chk("stream_no_overrun", int'(overrun), 0);
    send(50);
    cfg(0, 1);
    push(60, 60, 61);
    send(60); send(61);
    idle();

    // reset mid-window with a held result
    bus.out_ready = 1'b0;
    cfg(1, 2);
    send(1); send(2); send(3); send(4);
    chk("held_before_rst", int'(bus.out_valid), 1);
    send(9); send(9);
    rst = 1'b1;
    idle();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", sx(bus.out_data), 0);
    chk("rst_out_min", sx(bus.out_min), 0);
    chk("rst_out_max", sx(bus.out_max), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // clamped ratio: 31 behaves as 4096 samples
    cfg(1, 31);
    push(2047, 0, 4095);
    for (int i = 0; i < 4096; i++) begin
      send(i);
      if (i == 31 || i == 4094) chk("clamp_not_early", int'(bus.out_valid), 0);
    end
    chk("clamp_valid", int'(bus.out_valid), 1);
    repeat (3) idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
